// File: rtl/alu_out_stage.sv
// -----------------------------------------------------------------------------
// alu_out_stage
//
// This is a small result buffer (FIFO) that sits after the ALU logic units.
// Each entry holds an ALU result, its operation tag and a zero flag. The zero
// flag is captured when the entry is written, so the consumer sees a flag that
// belongs to the stored result. The head entry is shown on the outputs straight
// from storage. There is no write-through bypass, so a pushed result appears on
// the outputs one cycle after the push.
//
// Parameters
//   WIDTH     result width
//   DEPTH     number of entries; must be a power of two, 2 or more
//
// Ports
//   clk        single clock; all state updates on its rising edge
//   reset      asynchronous active-high reset
//   R          ALU result to enqueue
//   Op         operation tag that goes with R
//   in_valid   R/Op are valid this cycle
//   in_ready   buffer can accept R/Op this cycle (not full)
//   Q          result at the head entry (0 when empty)
//   OpQ        tag at the head entry (0 when empty)
//   Zero       stored zero flag of the head entry (0 when empty)
//   out_valid  head entry is present
//   out_ready  consumer takes the head entry this cycle
//   count      number of occupied entries
//   retired    number of entries popped since reset, modulo 256
// -----------------------------------------------------------------------------
module alu_out_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         R,
    input  logic [3:0]               Op,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         Q,
    output logic [3:0]               OpQ,
    output logic                     Zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               retired
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] dataMem [DEPTH];
    logic [3:0]       opMem   [DEPTH];
    logic             zeroMem [DEPTH];

    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [CW-1:0] countReg;
    logic [7:0]    retiredReg;

    logic doPush;
    logic doPop;
    logic isEmpty;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : ptr + PW'(1);
    endfunction

    // Handshake flags come only from registered occupancy. This means in_ready
    // never looks at out_ready, and a pop in the same cycle cannot free a slot
    // for a push when the buffer is full.
    assign isEmpty   = (countReg == '0);
    assign in_ready  = (countReg < FULL_COUNT);
    assign out_valid = !isEmpty;
    assign doPush    = in_valid && in_ready;
    assign doPop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dataMem[i] <= '0;
                opMem[i]   <= '0;
                zeroMem[i] <= 1'b0;
            end
        end else if (doPush) begin
            dataMem[tailPtr] <= R;
            opMem[tailPtr]   <= Op;
            zeroMem[tailPtr] <= (R == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            countReg   <= '0;
            retiredReg <= '0;
        end else begin
            if (doPush) begin
                tailPtr <= nextPtr(tailPtr);
            end
            if (doPop) begin
                headPtr    <= nextPtr(headPtr);
                retiredReg <= retiredReg + 8'd1;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // When the buffer is empty, the head slot may still hold an old value, so
    // the outputs are forced to zero.
    always_comb begin
        Q    = '0;
        OpQ  = '0;
        Zero = 1'b0;
        if (!isEmpty) begin
            Q    = dataMem[headPtr];
            OpQ  = opMem[headPtr];
            Zero = zeroMem[headPtr];
        end
    end

    assign count   = countReg;
    assign retired = retiredReg;

endmodule

// File: tb/tb_alu_out_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_out_stage
//
// Directed testbench for alu_out_stage with the default parameters
// (WIDTH=32, DEPTH=2). Inputs are driven 1 time unit after each rising edge,
// and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_alu_out_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] R = '0;
    logic [3:0]  Op = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Q;
    logic [3:0]  OpQ;
    logic        Zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  count;
    logic [7:0]  retired;

    int vectors = 0;
    int miscompares = 0;

    alu_out_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .R         (R),
        .Op        (Op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .OpQ       (OpQ),
        .Zero      (Zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (Q !== 32'h0) begin miscompares++; $display("FAIL reset_Q got=%h exp=0", Q); end
        vectors++; if (OpQ !== 4'h0) begin miscompares++; $display("FAIL reset_OpQ got=%h exp=0", OpQ); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL reset_Zero got=%b exp=0", Zero); end
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (retired !== 8'd0) begin miscompares++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    endtask

    task automatic test_single_push();
        do_reset();
        R = 32'hFFFF0000; Op = 4'h6; in_valid = 1'b1; out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        vectors++; if (Q !== 32'hFFFF0000) begin miscompares++; $display("FAIL single_Q got=%h exp=ffff0000", Q); end
        vectors++; if (OpQ !== 4'h6) begin miscompares++; $display("FAIL single_OpQ got=%h exp=6", OpQ); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL single_Zero got=%b exp=0", Zero); end
        vectors++; if (count !== 2'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        vectors++; if (Q !== 32'h0) begin miscompares++; $display("FAIL single_empty_Q got=%h exp=0", Q); end
        vectors++; if (retired !== 8'd1) begin miscompares++; $display("FAIL single_retired got=%0d exp=1", retired); end
        // Popping while empty must be ignored.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        vectors++; if (retired !== 8'd1) begin miscompares++; $display("FAIL empty_pop_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        out_ready = 1'b0;
        R = 32'h0; Op = 4'h1; in_valid = 1'b1;
        step();
        R = 32'h1; Op = 4'h2;
        step();
        vectors++; if (count !== 2'd2) begin miscompares++; $display("FAIL fill_count got=%0d exp=2", count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        vectors++; if (Zero !== 1'b1) begin miscompares++; $display("FAIL fill_Zero got=%b exp=1", Zero); end
        vectors++; if (OpQ !== 4'h1) begin miscompares++; $display("FAIL fill_OpQ got=%h exp=1", OpQ); end
        // This push while full must be dropped, even with out_ready high.
        R = 32'h2; Op = 4'h3; out_ready = 1'b1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready_ready got=%b exp=0", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (count !== 2'd1) begin miscompares++; $display("FAIL drop_count got=%0d exp=1", count); end
        vectors++; if (Q !== 32'h1) begin miscompares++; $display("FAIL pop1_Q got=%h exp=1", Q); end
        vectors++; if (Zero !== 1'b0) begin miscompares++; $display("FAIL pop1_Zero got=%b exp=0", Zero); end
        vectors++; if (OpQ !== 4'h2) begin miscompares++; $display("FAIL pop1_OpQ got=%h exp=2", OpQ); end
        step();
        out_ready = 1'b0;
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL drain_count got=%0d exp=0", count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
        vectors++; if (retired !== 8'd2) begin miscompares++; $display("FAIL drain_retired got=%0d exp=2", retired); end
    endtask

    task automatic test_concurrent();
        do_reset();
        R = 32'hDEAD; Op = 4'hF; in_valid = 1'b1; out_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] expHead;
            expHead = (i == 0) ? 32'hDEAD : 32'(i - 1);
            R = 32'(i); Op = 4'(i); in_valid = 1'b1; out_ready = 1'b1;
            vectors++; if (Q !== expHead) begin miscompares++; $display("FAIL concurrent_Q[%0d] got=%h exp=%h", i, Q, expHead); end
            step();
            vectors++; if (count !== 2'd1) begin miscompares++; $display("FAIL concurrent_count[%0d] got=%0d exp=1", i, count); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (Q !== 32'h9) begin miscompares++; $display("FAIL concurrent_last_Q got=%h exp=9", Q); end
        vectors++; if (retired !== 8'd10) begin miscompares++; $display("FAIL concurrent_retired got=%0d exp=10", retired); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            R = 32'h1000 + 32'(i); Op = 4'(i); in_valid = 1'b1; out_ready = 1'b0;
            step();
            in_valid = 1'b0; out_ready = 1'b1;
            vectors++; if (Q !== 32'h1000 + 32'(i) || OpQ !== 4'(i)) begin
                miscompares++; $display("FAIL wrap_head[%0d] got=%h/%h exp=%h/%h", i, Q, OpQ, 32'h1000 + 32'(i), 4'(i));
            end
            step();
        end
        out_ready = 1'b0;
        vectors++; if (retired !== 8'd44) begin miscompares++; $display("FAIL wrap_retired got=%0d exp=44", retired); end
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL wrap_count got=%0d exp=0", count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        R = 32'h11; Op = 4'h4; in_valid = 1'b1; out_ready = 1'b0;
        step();
        R = 32'h22; Op = 4'h5;
        step();
        in_valid = 1'b0;
        vectors++; if (count !== 2'd2) begin miscompares++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL areset_count got=%0d exp=0", count); end
        vectors++; if (Q !== 32'h0) begin miscompares++; $display("FAIL areset_Q got=%h exp=0", Q); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        // A push at an edge while reset is high must have no effect.
        R = 32'h33; in_valid = 1'b1;
        step();
        vectors++; if (count !== 2'd0) begin miscompares++; $display("FAIL reset_edge_push got=%0d exp=0", count); end
        reset = 1'b0;
        R = 32'hA5A5A5A5; Op = 4'h7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (Q !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL post_reset_Q got=%h exp=a5a5a5a5", Q); end
        vectors++; if (count !== 2'd1) begin miscompares++; $display("FAIL post_reset_count got=%0d exp=1", count); end
        vectors++; if (OpQ !== 4'h7) begin miscompares++; $display("FAIL post_reset_OpQ got=%h exp=7", OpQ); end
    endtask

    task automatic test_backpressure();
        do_reset();
        R = 32'h0; Op = 4'h3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            R = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h5A5A5A5A;
            Op = 4'(8 + i);
            in_valid = 1'b1;
            step();
            vectors++; if (Q !== 32'h0 || OpQ !== 4'h3 || Zero !== 1'b1) begin
                miscompares++; $display("FAIL hold[%0d] got=%h/%h/%b exp=0/3/1", i, Q, OpQ, Zero);
            end
        end
        in_valid = 1'b0;
        vectors++; if (count !== 2'd2) begin miscompares++; $display("FAIL hold_count got=%0d exp=2", count); end
        // The second entry was accepted on the first stall cycle.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (Q !== 32'hFFFFFFFF || OpQ !== 4'h8 || Zero !== 1'b0) begin
            miscompares++; $display("FAIL hold_second got=%h/%h/%b exp=ffffffff/8/0", Q, OpQ, Zero);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_concurrent();
        test_wrap();
        test_async_reset();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the result width.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the buffer entry count; legal values are powers of two, 2 or more.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port R, input, WIDTH, the ALU result from the logic units (AND/OR/NOR/...).
REQ-006 The block SHALL have port Op, input, 4, the ALU operation tag accompanying R.
REQ-007 The block SHALL have port in_valid, input, 1, meaning R/Op are valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts R/Op this cycle.
REQ-009 The block SHALL have port Q, output, WIDTH, the buffered result at the head entry.
REQ-010 The block SHALL have port OpQ, output, 4, the tag of the head entry.
REQ-011 The block SHALL have port Zero, output, 1, set when the head result is all zeros.
REQ-012 The block SHALL have port out_valid, output, 1, meaning the head entry is present.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the consumer takes the head entry this cycle.
REQ-014 The block SHALL have port count, output, log2(DEPTH)+1, the number of occupied entries.
REQ-015 The block SHALL have port retired, output, 8, the count of entries popped since reset.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready; it writes {R, Op, (R==0)} at the tail pointer.
REQ-017 Pop SHALL occur on a rising edge when out_valid && out_ready; it advances the head pointer.
REQ-018 in_ready SHALL equal (count < DEPTH), be registered-state-derived, and not depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 Q, OpQ and Zero SHALL present the head entry combinationally from storage; there is no bypass, so push-to-out_valid latency is 1 cycle.
REQ-021 Zero SHALL be computed at push time and stored per entry; it SHALL NOT be recomputed from Q.
REQ-022 While out_valid=1 and out_ready=0, Q/OpQ/Zero SHALL hold stable.
REQ-023 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full, in_ready=0 even if out_ready=1; in_valid is ignored.
REQ-026 When empty, out_ready is ignored; Q/OpQ/Zero SHALL be 0 when count=0.
REQ-027 retired SHALL increment by 1 per pop, wrapping 255 -> 0.
REQ-028 count SHALL never exceed DEPTH nor go below 0 under any input combination.

Reset
REQ-029 Asserting reset SHALL immediately, without a clock edge, clear pointers, count, retired and all entry storage to 0.
REQ-030 Reset outputs SHALL be: in_ready=1, out_valid=0, Q=0, OpQ=0, Zero=0, count=0, retired=0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered entries; the first push after deassertion lands in entry 0.
REQ-032 A push or pop coinciding with the clock edge on which reset is high SHALL have no effect.

Verification
REQ-033 Single push: R=32'hFFFF0000, Op=4'h6, out_ready=0 -> next cycle out_valid=1, Q=32'hFFFF0000, OpQ=6, Zero=0, count=1.
REQ-034 Fill and stall: push 32'h0 then 32'h1 with out_ready=0 -> count=2, in_ready=0, Zero=1 at head; a third push of 32'h2 is dropped; pops then return 0, 1 and count=0.
REQ-035 Concurrent push/pop at count=1 for 10 cycles with R=0..9 -> count stays 1, Q sequence is in order, retired=10.
REQ-036 Wrap: 300 push/pop pairs -> data order preserved across pointer wrap, retired=300 mod 256=44.
REQ-037 Async reset with count=2: assert reset between edges -> out_valid=0, count=0, Q=0 immediately; after release, push 32'hA5A5A5A5 appears at Q one cycle later.
REQ-038 Backpressure hold: out_valid=1, out_ready=0 for 5 cycles while R toggles -> Q/OpQ/Zero unchanged throughout.
